audio_envelope_vca: RTL and testbench



---
 rtl/audio_envelope_vca.sv | 159 +++++++++++++++
 tb/tb_audio_envelope_vca.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/audio_envelope_vca.sv
// ADSR envelope generator with an 8-bit offset-binary VCA for a single voice.
// Latency: sample_o is registered one cycle after sample_i/env; env/state update on envelope ticks.
// Backpressure: none; a sample is consumed and produced every clock cycle.
module audio_envelope_vca #(
    parameter int TICK_DIV = 256
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] sample_i,
    input  logic       gate_i,
    input  logic [7:0] attack_rate_i,
    input  logic [7:0] decay_rate_i,
    input  logic [7:0] sustain_level_i,
    input  logic [7:0] release_rate_i,
    output logic [7:0] sample_o,
    output logic [7:0] env_o,
    output logic [2:0] state_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    // Registered state
    env_state_t      state_q;
    logic [7:0]      env_q;
    logic            gate_dly_q;
    logic [PW-1:0]   presc_q;
    logic [7:0]      sample_q;

    // Tick and gate edge detection
    logic            tick;
    logic            rise;
    logic            fall;
    logic            gated_state;

    // Envelope arithmetic, all one bit wider than the level so saturation is visible
    logic [8:0]         att_sum;
    logic               att_sat;
    logic signed [8:0]  dec_diff;
    logic               dec_hit;
    logic               rel_done;

    // VCA datapath: centred sample times envelope, carried at product width
    logic signed [16:0] vca_c;
    logic signed [16:0] vca_e;
    logic signed [16:0] vca_p;
    logic [7:0]         vca_nxt;

    assign tick = (presc_q == PRESC_MAX);
    assign rise = gate_i & ~gate_dly_q;
    assign fall = ~gate_i & gate_dly_q;

    // A release only makes sense from a note that is still sounding under the key.
    assign gated_state = (state_q == ST_ATTACK) || (state_q == ST_DECAY) ||
                         (state_q == ST_SUSTAIN);

    assign att_sum  = {1'b0, env_q} + {1'b0, attack_rate_i};
    assign att_sat  = (att_sum >= 9'd255);

    // Signed compare so a decay step that undershoots zero still lands on sustain.
    assign dec_diff = $signed({1'b0, env_q}) - $signed({1'b0, decay_rate_i});
    assign dec_hit  = (dec_diff <= $signed({1'b0, sustain_level_i}));

    assign rel_done = (env_q <= release_rate_i);

    // Offset-binary to two's complement is an MSB flip; sign-extend to product width.
    assign vca_c   = {{9{~sample_i[7]}}, ~sample_i[7], sample_i[6:0]};
    assign vca_e   = {9'b0, env_q};
    assign vca_p   = vca_c * vca_e;
    // Floor divide by 256, then back to offset-binary by flipping the MSB again.
    assign vca_nxt = 8'(vca_p >>> 8) ^ 8'h80;

    // Free-running envelope prescaler and gate delay for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q    <= '0;
            gate_dly_q <= 1'b0;
        end else begin
            presc_q    <= tick ? '0 : presc_q + PW'(1);
            gate_dly_q <= gate_i;
        end
    end

    // ADSR state machine: gate edges take priority and suppress that cycle's tick update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            env_q   <= 8'd0;
        end else if (rise) begin
            // Retrigger keeps the current level to avoid a click.
            state_q <= ST_ATTACK;
        end else if (fall && gated_state) begin
            state_q <= ST_RELEASE;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    env_q <= 8'd0;
                end
                ST_ATTACK: begin
                    if (att_sat) begin
                        env_q   <= 8'd255;
                        state_q <= ST_DECAY;
                    end else begin
                        env_q   <= att_sum[7:0];
                    end
                end
                ST_DECAY: begin
                    if (dec_hit) begin
                        env_q   <= sustain_level_i;
                        state_q <= ST_SUSTAIN;
                    end else begin
                        env_q   <= dec_diff[7:0];
                    end
                end
                ST_SUSTAIN: begin
                    // Follows live sustain changes at tick resolution.
                    env_q <= sustain_level_i;
                end
                ST_RELEASE: begin
                    if (rel_done) begin
                        env_q   <= 8'd0;
                        state_q <= ST_IDLE;
                    end else begin
                        env_q   <= env_q - release_rate_i;
                    end
                end
                default: begin
                    // Unreachable encodings recover to silence.
                    env_q   <= 8'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered VCA output, idles at mid-scale
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_q <= 8'h80;
        end else begin
            sample_q <= vca_nxt;
        end
    end

    assign sample_o = sample_q;
    assign env_o    = env_q;
    assign state_o  = state_q;
    assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_audio_envelope_vca.sv
// Directed bench for audio_envelope_vca with a short envelope tick.
// Latency: checks taken 1 time unit after each rising edge.
// Backpressure: none; stimulus is a fixed cycle-indexed sequence.
module tb_audio_envelope_vca;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] sample_i;
    logic       gate_i;
    logic [7:0] attack_rate_i;
    logic [7:0] decay_rate_i;
    logic [7:0] sustain_level_i;
    logic [7:0] release_rate_i;
    logic [7:0] sample_o;
    logic [7:0] env_o;
    logic [2:0] state_o;
    logic       busy_o;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    audio_envelope_vca #(.TICK_DIV(4)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .sample_i        (sample_i),
        .gate_i          (gate_i),
        .attack_rate_i   (attack_rate_i),
        .decay_rate_i    (decay_rate_i),
        .sustain_level_i (sustain_level_i),
        .release_rate_i  (release_rate_i),
        .sample_o        (sample_o),
        .env_o           (env_o),
        .state_o         (state_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle; cyc counts edges since reset was released.
    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) step();
    endtask

    initial begin
        rst_i           = 1'b1;
        gate_i          = 1'b1;
        sample_i        = 8'hFF;
        attack_rate_i   = 8'd64;
        decay_rate_i    = 8'd32;
        sustain_level_i = 8'd100;
        release_rate_i  = 8'd50;

        // Reset held for three edges with the gate high
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        chk("rst_sample", sample_o, 8'h80);
        chk("rst_env",    env_o,    0);
        chk("rst_state",  state_o,  0);
        chk("rst_busy",   busy_o,   0);

        rst_i = 1'b0;
        cyc   = 0;
        run_to(1);
        chk("post_rst_rise_state", state_o, 1);
        chk("post_rst_rise_env",   env_o,   0);
        chk("post_rst_busy",       busy_o,  1);

        // Full ADSR: ticks land on edges 4, 8, 12, ...
        run_to(3);  chk("att_pre_tick", env_o, 0);
        run_to(4);  chk("att_t1", env_o, 64);
        run_to(8);  chk("att_t2", env_o, 128);
        run_to(12); chk("att_t3", env_o, 192);
        run_to(16); chk("att_t4", env_o, 255); chk("att_to_decay", state_o, 2);
        run_to(20); chk("dec_t1", env_o, 223);
        run_to(24); chk("dec_t2", env_o, 191);
        run_to(28); chk("dec_t3", env_o, 159);
        run_to(32); chk("dec_t4", env_o, 127); chk("dec_still", state_o, 2);
        run_to(36); chk("dec_t5", env_o, 100); chk("to_sustain", state_o, 3);

        // Gate fall coincides with the tick on edge 40; sustain moved so a stray update shows.
        run_to(39);
        gate_i          = 1'b0;
        sustain_level_i = 8'd90;
        run_to(40); chk("fall_tick_state", state_o, 4); chk("fall_tick_env", env_o, 100);
        run_to(44); chk("rel_t1", env_o, 50);
        run_to(47); chk("rel_busy_before", busy_o, 1);
        run_to(48);
        chk("rel_t2_env",   env_o,   0);
        chk("rel_to_idle",  state_o, 0);
        chk("rel_busy_off", busy_o,  0);

        // Attack 255 saturates in one tick; decay 255 reaches sustain in one tick.
        attack_rate_i   = 8'd255;
        decay_rate_i    = 8'd255;
        sustain_level_i = 8'd128;
        gate_i          = 1'b1;
        run_to(49); chk("rise_from_idle", state_o, 1);
        run_to(52); chk("att255_env", env_o, 255); chk("att255_state", state_o, 2);

        // VCA at full envelope
        sample_i = 8'h00;
        run_to(53); chk("vca255_00", sample_o, 8'h00);
        sample_i = 8'hFF;
        run_to(54); chk("vca255_ff", sample_o, 8'hFE);
        run_to(56); chk("dec255_env", env_o, 128); chk("dec255_state", state_o, 3);

        // VCA at half envelope, with one cycle of latency
        run_to(57); chk("vca128_ff", sample_o, 8'hBF);
        sample_i = 8'h00;
        #1;         chk("vca_latency_hold", sample_o, 8'hBF);
        run_to(58); chk("vca128_00", sample_o, 8'h40);
        sample_i = 8'h80;
        run_to(59); chk("vca128_80", sample_o, 8'h80);

        // Sustain follows a live change on the next tick
        sustain_level_i = 8'd150;
        run_to(60); chk("sus_track", env_o, 150);

        // Release rate 0 holds the level indefinitely
        gate_i         = 1'b0;
        release_rate_i = 8'd0;
        run_to(61); chk("fall_to_rel", state_o, 4);
        run_to(68);
        chk("rel0_env",   env_o,   150);
        chk("rel0_state", state_o, 4);
        chk("rel0_busy",  busy_o,  1);

        // Retrigger from release keeps the level
        attack_rate_i = 8'd64;
        gate_i        = 1'b1;
        run_to(69); chk("retrig_state", state_o, 1); chk("retrig_env", env_o, 150);
        run_to(72); chk("retrig_att", env_o, 214);

        // Sustain at 255: decay exits on its first tick
        sustain_level_i = 8'd255;
        decay_rate_i    = 8'd32;
        run_to(76); chk("sat_env", env_o, 255); chk("sat_state", state_o, 2);
        run_to(80); chk("sus255_state", state_o, 3); chk("sus255_env", env_o, 255);
        sample_i = 8'h00;
        run_to(81); chk("vca255_00_b", sample_o, 8'h00);

        // Mid-note reset aborts immediately
        rst_i = 1'b1;
        run_to(82);
        chk("mid_rst_state",  state_o,  0);
        chk("mid_rst_env",    env_o,    0);
        chk("mid_rst_sample", sample_o, 8'h80);
        chk("mid_rst_busy",   busy_o,   0);
        rst_i = 1'b0;
        run_to(83); chk("mid_rst_rise", state_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
